// File: rtl/hls_run_sequencer.sv
// hls_run_sequencer: host-side run controller for a Bambu accelerator.
// Performs single-byte slave RAM writes/reads, launches runs, measures run
// latency in cycles and aborts runs that exceed a programmable watchdog.
module hls_run_sequencer #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int MEM_TO = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [31:0]       timeout_cycles,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_data,
    output logic [31:0]       rsp_cycles,
    output logic              busy,
    output logic              acc_start,
    input  logic              acc_done,
    output logic              acc_reset,
    output logic              s_oe,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic [7:0]        s_size,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_rdy
);

    typedef enum logic [2:0] {IDLE, MWR, MRD, START, RUN, ABORT, RESP} state_t;

    localparam int MCW = $clog2(MEM_TO + 1);
    localparam logic [MCW-1:0] MEM_LAST = MCW'(MEM_TO - 1);

    state_t            state, state_n;
    logic [MCW-1:0]    mem_cnt, mem_cnt_n;
    logic [31:0]       cyc_cnt, cyc_cnt_n;
    logic              abort_cnt, abort_cnt_n;
    logic              rsp_valid_n, busy_n, acc_start_n, acc_reset_n;
    logic              s_oe_n, s_we_n;
    logic [1:0]        rsp_status_n;
    logic [DATA_W-1:0] rsp_data_n, s_wdata_n;
    logic [31:0]       rsp_cycles_n;
    logic [ADDR_W-1:0] s_addr_n;
    logic [7:0]        s_size_n;
    logic [31:0]       cyc_inc;

    assign cmd_ready = (state == IDLE);
    assign cyc_inc   = (cyc_cnt == 32'hFFFF_FFFF) ? cyc_cnt : cyc_cnt + 32'd1;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_n      = state;
        mem_cnt_n    = mem_cnt;
        cyc_cnt_n    = cyc_cnt;
        abort_cnt_n  = abort_cnt;
        rsp_valid_n  = rsp_valid;
        rsp_status_n = rsp_status;
        rsp_data_n   = rsp_data;
        rsp_cycles_n = rsp_cycles;
        acc_start_n  = acc_start;
        acc_reset_n  = acc_reset;
        s_oe_n       = s_oe;
        s_we_n       = s_we;
        s_addr_n     = s_addr;
        s_wdata_n    = s_wdata;
        s_size_n     = s_size;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    rsp_status_n = 2'd0;
                    rsp_data_n   = '0;
                    rsp_cycles_n = '0;
                    case (cmd_op)
                        2'd0: begin
                            state_n   = MWR;
                            s_we_n    = 1'b1;
                            s_addr_n  = cmd_addr;
                            s_wdata_n = cmd_wdata;
                            s_size_n  = 8'(DATA_W);
                            mem_cnt_n = '0;
                        end
                        2'd1: begin
                            state_n   = MRD;
                            s_oe_n    = 1'b1;
                            s_addr_n  = cmd_addr;
                            s_size_n  = 8'(DATA_W);
                            mem_cnt_n = '0;
                        end
                        2'd2: begin
                            state_n     = START;
                            acc_start_n = 1'b1;
                            cyc_cnt_n   = 32'd1;
                        end
                        default: begin
                            state_n      = RESP;
                            rsp_status_n = 2'd3;
                            rsp_valid_n  = 1'b1;
                        end
                    endcase
                end
            end
            MWR, MRD: begin
                if (s_rdy || mem_cnt == MEM_LAST) begin
                    state_n     = RESP;
                    rsp_valid_n = 1'b1;
                    s_oe_n      = 1'b0;
                    s_we_n      = 1'b0;
                    s_addr_n    = '0;
                    s_wdata_n   = '0;
                    s_size_n    = '0;
                    if (s_rdy) begin
                        rsp_status_n = 2'd0;
                        rsp_data_n   = (state == MRD) ? s_rdata : '0;
                    end else begin
                        rsp_status_n = 2'd2;
                        rsp_data_n   = '0;
                    end
                end else begin
                    mem_cnt_n = mem_cnt + 1'b1;
                end
            end
            START: begin
                acc_start_n = 1'b0;
                cyc_cnt_n   = cyc_inc;
                state_n     = RUN;
            end
            RUN: begin
                if (acc_done) begin
                    rsp_cycles_n = cyc_cnt;
                    rsp_status_n = 2'd0;
                    rsp_valid_n  = 1'b1;
                    state_n      = RESP;
                end else if (timeout_cycles != 32'd0 && cyc_cnt == timeout_cycles) begin
                    rsp_cycles_n = timeout_cycles;
                    acc_reset_n  = 1'b1;
                    abort_cnt_n  = 1'b0;
                    state_n      = ABORT;
                end else begin
                    cyc_cnt_n = cyc_inc;
                end
            end
            ABORT: begin
                if (abort_cnt) begin
                    acc_reset_n  = 1'b0;
                    rsp_status_n = 2'd1;
                    rsp_valid_n  = 1'b1;
                    state_n      = RESP;
                end else begin
                    abort_cnt_n = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs; synchronous reset drops everything back to idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            mem_cnt    <= '0;
            cyc_cnt    <= '0;
            abort_cnt  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'd0;
            rsp_data   <= '0;
            rsp_cycles <= '0;
            busy       <= 1'b0;
            acc_start  <= 1'b0;
            acc_reset  <= 1'b0;
            s_oe       <= 1'b0;
            s_we       <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_size     <= '0;
        end else begin
            state      <= state_n;
            mem_cnt    <= mem_cnt_n;
            cyc_cnt    <= cyc_cnt_n;
            abort_cnt  <= abort_cnt_n;
            rsp_valid  <= rsp_valid_n;
            rsp_status <= rsp_status_n;
            rsp_data   <= rsp_data_n;
            rsp_cycles <= rsp_cycles_n;
            busy       <= busy_n;
            acc_start  <= acc_start_n;
            acc_reset  <= acc_reset_n;
            s_oe       <= s_oe_n;
            s_we       <= s_we_n;
            s_addr     <= s_addr_n;
            s_wdata    <= s_wdata_n;
            s_size     <= s_size_n;
        end
    end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// tb_hls_run_sequencer: directed and randomized commands against a
// behavioural model of the sequencer, with simple slave-RAM and accelerator models.
module tb_hls_run_sequencer;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int MEM_TO = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [1:0]        cmd_op, rsp_status;
    logic [ADDR_W-1:0] cmd_addr, s_addr;
    logic [DATA_W-1:0] cmd_wdata, rsp_data, s_wdata, s_rdata;
    logic [31:0]       timeout_cycles, rsp_cycles;
    logic              acc_start, acc_done, acc_reset, s_oe, s_we, s_rdy;
    logic [7:0]        s_size;

    hls_run_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TO(MEM_TO)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .timeout_cycles(timeout_cycles),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .rsp_cycles(rsp_cycles), .busy(busy),
        .acc_start(acc_start), .acc_done(acc_done), .acc_reset(acc_reset),
        .s_oe(s_oe), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_size(s_size), .s_rdata(s_rdata), .s_rdy(s_rdy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  status;
        logic [7:0]  data;
        logic [31:0] cycles;
        int          latency;
        int          we_cyc;
        int          oe_cyc;
        int          start_cyc;
        int          areset_cyc;
    } exp_t;

    int total = 0;
    int bad = 0;

    // Environment knobs: slave ready delay (0 = never) and accelerator done delay (0 = never)
    int slv_delay = 1;
    int done_delay = 0;
    bit [7:0] slv_mem [128];
    bit [7:0] ref_mem [128];
    int strobe_run = 0;
    int run_cnt = 0;
    logic run_active = 1'b0;

    int we_cnt = 0, oe_cnt = 0, start_cnt = 0, ares_cnt = 0, proto_err = 0;
    int we0, oe0, start0, ares0;

    assign s_rdy    = (s_we || s_oe) && slv_delay != 0 && (strobe_run + 1 == slv_delay);
    assign s_rdata  = slv_mem[s_addr];
    assign acc_done = run_active && done_delay != 0 && run_cnt == done_delay;

    // Slave RAM and accelerator behaviour
    always @(posedge clock) begin
        if (reset) strobe_run <= 0;
        else if ((s_we || s_oe) && !s_rdy) strobe_run <= strobe_run + 1;
        else strobe_run <= 0;
        if (s_we && s_rdy) slv_mem[s_addr] <= s_wdata;
        if (reset || acc_reset || acc_done) begin
            run_active <= 1'b0;
            run_cnt    <= 0;
        end else if (acc_start) begin
            run_active <= 1'b1;
            run_cnt    <= 1;
        end else if (run_active) begin
            run_cnt <= run_cnt + 1;
        end
    end

    // Activity counters and slave-port sanity watcher
    always @(negedge clock) begin
        we_cnt    <= we_cnt + int'(s_we);
        oe_cnt    <= oe_cnt + int'(s_oe);
        start_cnt <= start_cnt + int'(acc_start);
        ares_cnt  <= ares_cnt + int'(acc_reset);
        if ((s_we && s_oe) ||
            (!s_we && !s_oe && (s_addr != '0 || s_wdata != '0 || s_size != 8'd0)) ||
            ((s_we || s_oe) && s_size != 8'(DATA_W)))
            proto_err <= proto_err + 1;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [6:0] addr,
                                   input int sdelay, input int ddelay, input logic [31:0] tmo);
        exp_t e;
        bit mem_ok, wd_fire;
        e = '{status: 2'd0, data: 8'd0, cycles: 32'd0, latency: 1,
              we_cyc: 0, oe_cyc: 0, start_cyc: 0, areset_cyc: 0};
        mem_ok = (sdelay >= 1 && sdelay <= MEM_TO);
        case (op)
            2'd0, 2'd1: begin
                if (mem_ok) begin
                    e.latency = sdelay + 1;
                    if (op == 2'd1) e.data = ref_mem[addr];
                end else begin
                    e.status  = 2'd2;
                    e.latency = MEM_TO + 1;
                end
                if (op == 2'd0) e.we_cyc = mem_ok ? sdelay : MEM_TO;
                else            e.oe_cyc = mem_ok ? sdelay : MEM_TO;
            end
            2'd2: begin
                // Run length counts the start cycle as 1, so done after D cycles reports D+1
                e.start_cyc = 1;
                wd_fire = (tmo >= 2) && (ddelay == 0 || int'(tmo) < ddelay + 1);
                if (wd_fire) begin
                    e.status     = 2'd1;
                    e.cycles     = tmo;
                    e.areset_cyc = 2;
                    e.latency    = int'(tmo) + 3;
                end else begin
                    e.cycles  = 32'(ddelay + 1);
                    e.latency = ddelay + 2;
                end
            end
            default: e.status = 2'd3;
        endcase
        return e;
    endfunction

    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [6:0] addr,
                                 input logic [7:0] wdata);
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        checkOutput({name, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(posedge clock);
        we0 = we_cnt; oe0 = oe_cnt; start0 = start_cnt; ares0 = ares_cnt;
        @(negedge clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        checkOutput({name, ".first"}, {60'd0, s_we, s_oe, acc_start, busy},
                    {60'd0, op == 2'd0, op == 2'd1, op == 2'd2, 1'b1});
        if (op == 2'd0 || op == 2'd1)
            checkOutput({name, ".s_addr"}, 64'(s_addr), 64'(addr));
    endtask

    task automatic checkCommand(input string name, input logic [1:0] op, input logic [6:0] addr,
                                input logic [7:0] wdata, input int sdelay, input int ddelay,
                                input logic [31:0] tmo, input int hold);
        exp_t e;
        int lat;
        bit stable;
        logic [1:0] st;
        logic [7:0] dt;
        logic [31:0] cy;
        slv_delay      = sdelay;
        done_delay     = ddelay;
        timeout_cycles = tmo;
        e = model(op, addr, sdelay, ddelay, tmo);
        applyStimulus(name, op, addr, wdata);
        lat = 1;
        while (!rsp_valid && lat < 600) begin
            @(negedge clock);
            lat++;
        end
        st = rsp_status; dt = rsp_data; cy = rsp_cycles;
        stable = !cmd_ready;
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            if (!rsp_valid || rsp_status != st || rsp_data != dt || rsp_cycles != cy || cmd_ready)
                stable = 1'b0;
        end
        if (hold > 0) checkOutput({name, ".hold"}, 64'(stable), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clock);
        checkOutput({name, ".we_cyc"}, 64'(we_cnt - we0), 64'(e.we_cyc));
        checkOutput({name, ".oe_cyc"}, 64'(oe_cnt - oe0), 64'(e.oe_cyc));
        checkOutput({name, ".start_cyc"}, 64'(start_cnt - start0), 64'(e.start_cyc));
        checkOutput({name, ".areset_cyc"}, 64'(ares_cnt - ares0), 64'(e.areset_cyc));
        @(negedge clock);
        rsp_ready = 1'b0;
        checkOutput({name, ".latency"}, 64'(lat), 64'(e.latency));
        checkOutput({name, ".status"}, 64'(st), 64'(e.status));
        checkOutput({name, ".data"}, 64'(dt), 64'(e.data));
        checkOutput({name, ".cycles"}, 64'(cy), 64'(e.cycles));
        checkOutput({name, ".after"}, {61'd0, rsp_valid, cmd_ready, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
        if (op == 2'd0 && e.status == 2'd0) ref_mem[addr] = wdata;
    endtask

    initial begin
        logic [1:0] op;
        int sd, dd, hold;
        logic [31:0] tmo;
        bit saw_valid;
        int ares_snap;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
        timeout_cycles = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_state",
                    {rsp_valid, rsp_status, rsp_data, rsp_cycles, busy, acc_start, acc_reset,
                     s_oe, s_we, s_addr, s_wdata, s_size}, 64'd0);
        checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;

        $display("[TB] directed commands");
        checkCommand("wr_a5", 2'd0, 7'h12, 8'hA5, 1, 0, 32'd0, 0);
        checkCommand("rd_12", 2'd1, 7'h12, 8'h00, 2, 0, 32'd0, 0);
        checkCommand("run_done10", 2'd2, 7'h00, 8'h00, 1, 10, 32'd0, 0);
        checkCommand("watchdog50", 2'd2, 7'h00, 8'h00, 1, 0, 32'd50, 0);
        checkCommand("run_after_wd", 2'd2, 7'h00, 8'h00, 1, 3, 32'd0, 0);
        checkCommand("rd_stuck", 2'd1, 7'h12, 8'h00, 0, 0, 32'd0, 0);
        checkCommand("illegal", 2'd3, 7'h33, 8'h77, 1, 5, 32'd0, 0);
        checkCommand("done_eq_wd", 2'd2, 7'h00, 8'h00, 1, 19, 32'd20, 0);
        checkCommand("wr_edge16", 2'd0, 7'h7F, 8'h3C, 16, 0, 32'd0, 0);
        checkCommand("wr_late17", 2'd0, 7'h01, 8'hEE, 17, 0, 32'd0, 0);
        checkCommand("rd_edge", 2'd1, 7'h7F, 8'h00, 3, 0, 32'd0, 0);
        checkCommand("rd_late", 2'd1, 7'h01, 8'h00, 4, 0, 32'd0, 0);
        checkCommand("backpressure", 2'd1, 7'h12, 8'h00, 1, 0, 32'd0, 5);

        $display("[TB] reset during a run");
        slv_delay = 1; done_delay = 0; timeout_cycles = 32'd0;
        applyStimulus("rst_run", 2'd2, 7'h00, 8'h00);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("rst_run.outputs",
                    {rsp_valid, rsp_status, rsp_data, rsp_cycles, busy, acc_start, acc_reset,
                     s_oe, s_we, s_addr, s_wdata, s_size}, 64'd0);
        checkOutput("rst_run.cmd_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;
        ares_snap = ares_cnt;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (rsp_valid) saw_valid = 1'b1;
        end
        checkOutput("rst_run.no_rsp", 64'(saw_valid), 64'd0);
        checkOutput("rst_run.no_abort", 64'(ares_cnt - ares_snap), 64'd0);

        $display("[TB] randomized commands");
        for (int n = 0; n < 30; n++) begin
            op   = 2'($urandom_range(0, 3));
            sd   = $urandom_range(0, MEM_TO + 2);
            dd   = $urandom_range(1, 25);
            tmo  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(2, 30));
            if (tmo != 32'd0 && $urandom_range(0, 4) == 0) dd = 0;
            hold = $urandom_range(0, 3);
            checkCommand($sformatf("rnd%0d", n), op, 7'($urandom_range(0, 127)),
                         8'($urandom_range(0, 255)), sd, dd, tmo, hold);
        end

        checkOutput("slave_port_rules", 64'(proto_err), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hls_run_sequencer.md
# hls_run_sequencer

Run controller for one Bambu-generated accelerator (`main` top with slave RAM port and `start_port`/`done_port` handshake). It accepts host commands to write or read accelerator-internal memory through the slave port, and to launch a run. It measures run latency in clock cycles and enforces a watchdog. Placed between the host/debug interface and the accelerator; it drives slave channel 0 only, and the top level ties channel 1 to zero.

## Interface
- `ADDR_W`, default 7: slave address width (one channel).
- `DATA_W`, default 8: slave data width (one channel).
- `MEM_TO`, default 16: cycles allowed for a slave access before an error is reported.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_op` in 2: 0 = write byte, 1 = read byte, 2 = run, 3 = illegal.
- `cmd_addr` in ADDR_W: slave address.
- `cmd_wdata` in DATA_W: write data.
- `timeout_cycles` in 32: run watchdog limit; 0 disables the watchdog.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed.
- `rsp_status` out 2: 0 = OK, 1 = run timeout, 2 = memory timeout, 3 = illegal op.
- `rsp_data` out DATA_W: read data; 0 for all non-read ops.
- `rsp_cycles` out 32: run latency; 0 for all non-run ops.
- `busy` out 1: high in every state except IDLE.
- `acc_start` out 1: drives the accelerator `start_port`.
- `acc_done` in 1: from the accelerator `done_port`.
- `acc_reset` out 1: active-high accelerator reset request; the top level inverts it for Bambu.
- `s_oe`, `s_we` out 1 each: slave read / write strobe.
- `s_addr` out ADDR_W: slave address.
- `s_wdata` out DATA_W: slave write data.
- `s_size` out 8: access size in bits.
- `s_rdata` in DATA_W: slave read data.
- `s_rdy` in 1: slave DataRdy for channel 0.

## Operation
States: IDLE, MWR, MRD, START, RUN, ABORT, RESP.
- **IDLE**
  - `cmd_ready`=1.
  - On handshake, latch `cmd_addr`, `cmd_wdata` and `cmd_op`.
  - Next state by op: 0 → MWR, 1 → MRD, 2 → START, 3 → RESP with status 3.
- **MWR**
  - Hold `s_we`=1, `s_addr`, `s_wdata`, and `s_size`=DATA_W.
  - On `s_rdy`=1: drop the strobe and go to RESP, status 0.
- **MRD**
  - Hold `s_oe`=1, `s_addr`, and `s_size`=DATA_W.
  - On `s_rdy`=1: capture `s_rdata` into `rsp_data`, go to RESP, status 0.
- **Memory access timeout (MWR/MRD)**
  - An access counter clears on entry and increments every cycle.
  - When it reaches MEM_TO with no `s_rdy`: drop the strobe, go to RESP, status 2, `rsp_data`=0.
- **START**
  - `acc_start`=1 for exactly this one cycle.
  - Cycle counter loads 1.
  - `acc_done` is ignored in this cycle.
  - Go to RUN.
- **RUN**
  - Counter increments by 1 per cycle and saturates at 0xFFFFFFFF.
  - `acc_done`=1: `rsp_cycles` = counter value in that cycle; go to RESP, status 0.
  - Counter equal to `timeout_cycles` (nonzero) with `acc_done`=0: `rsp_cycles`=`timeout_cycles`; go to ABORT.
  - `acc_done` and timeout in the same cycle: done wins, status 0.
- **ABORT**
  - `acc_reset`=1 for exactly 2 cycles.
  - Then go to RESP, status 1.
- **RESP**
  - `rsp_valid`=1; `rsp_status`, `rsp_data` and `rsp_cycles` are held stable.
  - Return to IDLE on `rsp_ready`=1.
- The slave strobes are never asserted outside MWR/MRD. `s_addr`, `s_wdata` and `s_size` are 0 whenever no strobe is active.
- Commands cannot be accepted while `busy`=1; `cmd_valid` is ignored then.

## Timing
- All outputs are registered except `cmd_ready`, which is combinational from state = IDLE.
- Reset values:
  - State IDLE.
  - `acc_start`, `acc_reset`, `s_oe`, `s_we` = 0.
  - `s_addr`, `s_wdata`, `s_size` = 0.
  - `rsp_valid`=0, `rsp_status`=0, `rsp_data`=0, `rsp_cycles`=0.
  - `busy`=0.
- Reset in any state, including mid-run or mid-access, returns to IDLE on the next edge. No response is issued and `acc_reset` is not pulsed.
- Latencies:
  - Command handshake to strobe asserted: 1 cycle.
  - `s_rdy` sampled to `rsp_valid`: 1 cycle.
  - Run command handshake to `acc_start`: 1 cycle.
  - `acc_done` sampled to `rsp_valid`: 1 cycle.
- Back-to-back commands: the earliest next `cmd_ready` is the cycle after the `rsp_valid`/`rsp_ready` handshake.
- Cycle count convention: done in the first RUN cycle gives `rsp_cycles`=2.

## Test plan
- **Write then read:** write 0xA5 to address 0x12, then read 0x12, with the slave model using write delay 1 and read delay 2. Expect `s_we` held for 1 cycle and `s_oe` held for 2 cycles, both responses status 0, read `rsp_data`=0xA5.
- **Run to completion:** `timeout_cycles`=0, model asserts `acc_done` 10 cycles after `acc_start`. Expect a single-cycle `acc_start` pulse, `rsp_cycles`=11, status 0.
- **Watchdog:** `timeout_cycles`=50, `acc_done` never asserted. Expect `acc_reset` high for exactly 2 cycles, then status 1 with `rsp_cycles`=50. A subsequent run command must be accepted.
- **Memory timeout and illegal op:**
  - Read with `s_rdy` stuck low: status 2 after 16 cycles, `rsp_data`=0, `s_oe` deasserted.
  - `cmd_op`=3: status 3 with no slave or accelerator activity.
- **Simultaneous done and timeout:** `timeout_cycles`=20 with `acc_done` asserted in the cycle the counter reaches 20. Expect status 0, `rsp_cycles`=20, no `acc_reset`.
- **Backpressure and reset:**
  - `rsp_ready` held low for 5 cycles: response fields stable and `cmd_ready`=0 throughout.
  - Reset asserted mid-RUN: all outputs at reset values on the next edge and no `rsp_valid`.
